// File: rtl/proc_io_responder_if.sv
// Bundle of processor port, upstream source and downstream sink signals
// seen by the SAPHO environment-side I/O responder.
interface proc_io_responder_if #(
  parameter int unsigned NCH = 3,
  parameter int unsigned DW  = 32
);
  logic [NCH-1:0]    req_in;
  logic [DW-1:0]     in_proc;
  logic [NCH-1:0]    out_en;
  logic [DW-1:0]     out_proc;
  logic [NCH*DW-1:0] src_data;
  logic [NCH-1:0]    src_valid;
  logic [NCH-1:0]    src_ready;
  logic [NCH*DW-1:0] snk_data;
  logic [NCH-1:0]    snk_valid;
  logic [NCH-1:0]    snk_ready;
  logic              clr_flags;
  logic [NCH-1:0]    underflow;
  logic [NCH-1:0]    overflow;
  logic              err_onehot;

  modport slave (
    input  req_in, out_en, out_proc, src_data, src_valid, snk_ready, clr_flags,
    output in_proc, src_ready, snk_data, snk_valid, underflow, overflow, err_onehot
  );

  modport master (
    output req_in, out_en, out_proc, src_data, src_valid, snk_ready, clr_flags,
    input  in_proc, src_ready, snk_data, snk_valid, underflow, overflow, err_onehot
  );
endinterface

// File: rtl/proc_io_responder.sv
// SAPHO one-hot port responder: per-channel input FIFOs read by req_in,
// per-channel output FIFOs filled by out_en and drained by valid/ready sinks.
module proc_io_responder #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_geral,
  proc_io_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0]  r_in_mem  [NCH][DEPTH];
  logic [DW-1:0]  r_out_mem [NCH][DEPTH];
  logic [AW-1:0]  r_in_wp   [NCH];
  logic [AW-1:0]  r_in_rp   [NCH];
  logic [AW-1:0]  r_out_wp  [NCH];
  logic [AW-1:0]  r_out_rp  [NCH];
  logic [CW-1:0]  r_in_cnt  [NCH];
  logic [CW-1:0]  r_out_cnt [NCH];
  logic [NCH-1:0] r_underflow;
  logic [NCH-1:0] r_overflow;
  logic           r_err_onehot;

  logic              w_req_oh, w_req_multi, w_en_oh, w_en_multi;
  logic [NCH-1:0]    w_in_empty, w_in_full, w_out_empty, w_out_full;
  logic [NCH-1:0]    w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic [NCH-1:0]    w_udf_set, w_ovf_set;
  logic [DW-1:0]     w_in_proc;
  logic [NCH*DW-1:0] w_snk_data;

  // Handshake decode; full/empty come only from registered occupancy
  always_comb begin
    w_req_oh    = (bus.req_in != '0) && ((bus.req_in & (bus.req_in - NCH'(1))) == '0);
    w_req_multi = (bus.req_in != '0) && !w_req_oh;
    w_en_oh     = (bus.out_en != '0) && ((bus.out_en & (bus.out_en - NCH'(1))) == '0);
    w_en_multi  = (bus.out_en != '0) && !w_en_oh;
    w_in_empty  = '0;
    w_in_full   = '0;
    w_out_empty = '0;
    w_out_full  = '0;
    w_in_push   = '0;
    w_in_pop    = '0;
    w_out_push  = '0;
    w_out_pop   = '0;
    w_udf_set   = '0;
    w_ovf_set   = '0;
    w_in_proc   = '0;
    w_snk_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      w_in_empty[k]  = (r_in_cnt[k] == '0);
      w_in_full[k]   = (r_in_cnt[k] == FULL);
      w_out_empty[k] = (r_out_cnt[k] == '0);
      w_out_full[k]  = (r_out_cnt[k] == FULL);
      w_in_push[k]   = bus.src_valid[k] && !w_in_full[k];
      w_in_pop[k]    = w_req_oh && bus.req_in[k] && !w_in_empty[k];
      w_udf_set[k]   = w_req_oh && bus.req_in[k] && w_in_empty[k];
      w_out_push[k]  = w_en_oh && bus.out_en[k] && !w_out_full[k];
      w_ovf_set[k]   = w_en_oh && bus.out_en[k] && w_out_full[k];
      w_out_pop[k]   = bus.snk_ready[k] && !w_out_empty[k];
      if (w_in_pop[k]) w_in_proc = r_in_mem[k][r_in_rp[k]];
      if (!w_out_empty[k]) w_snk_data[k*DW +: DW] = r_out_mem[k][r_out_rp[k]];
    end
  end

  // Storage arrays carry no reset; empty FIFOs present zero instead
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (w_in_push[k])  r_in_mem[k][r_in_wp[k]]   <= bus.src_data[k*DW +: DW];
      if (w_out_push[k]) r_out_mem[k][r_out_wp[k]] <= bus.out_proc;
    end
  end

  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral) begin
      for (int k = 0; k < NCH; k++) begin
        r_in_wp[k]   <= '0;
        r_in_rp[k]   <= '0;
        r_out_wp[k]  <= '0;
        r_out_rp[k]  <= '0;
        r_in_cnt[k]  <= '0;
        r_out_cnt[k] <= '0;
      end
      r_underflow  <= '0;
      r_overflow   <= '0;
      r_err_onehot <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_in_push[k])  r_in_wp[k]  <= r_in_wp[k] + AW'(1);
        if (w_in_pop[k])   r_in_rp[k]  <= r_in_rp[k] + AW'(1);
        if (w_out_push[k]) r_out_wp[k] <= r_out_wp[k] + AW'(1);
        if (w_out_pop[k])  r_out_rp[k] <= r_out_rp[k] + AW'(1);
        r_in_cnt[k]  <= r_in_cnt[k] + CW'(w_in_push[k]) - CW'(w_in_pop[k]);
        r_out_cnt[k] <= r_out_cnt[k] + CW'(w_out_push[k]) - CW'(w_out_pop[k]);
      end
      // A set event in the clearing cycle survives the clear
      r_underflow  <= (bus.clr_flags ? '0 : r_underflow) | w_udf_set;
      r_overflow   <= (bus.clr_flags ? '0 : r_overflow) | w_ovf_set;
      r_err_onehot <= (bus.clr_flags ? 1'b0 : r_err_onehot) | w_req_multi | w_en_multi;
    end
  end

  assign bus.in_proc    = w_in_proc;
  assign bus.src_ready  = ~w_in_full;
  assign bus.snk_valid  = ~w_out_empty;
  assign bus.snk_data   = w_snk_data;
  assign bus.underflow  = r_underflow;
  assign bus.overflow   = r_overflow;
  assign bus.err_onehot = r_err_onehot;
endmodule
